// File: rtl/aes_block_packer_if.sv
// aes_block_packer_if: byte-stream input and 128-bit block output of the AES front end.
//   s_valid/s_ready/s_data/s_last : incoming message bytes, s_last marks the final byte
//   m_valid/m_ready               : block handshake toward the AES core
//   m_plaintext/m_key/m_last      : packed block, key snapshot, final-block flag
//   modport slave  : the packer (consumes bytes, produces blocks)
//   modport master : the environment (produces bytes, consumes blocks)
interface aes_block_packer_if;
    logic         s_valid;
    logic         s_ready;
    logic [7:0]   s_data;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_plaintext;
    logic [127:0] m_key;
    logic         m_last;
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_plaintext, m_key, m_last
    );
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_plaintext, m_key, m_last
    );
endinterface

// File: rtl/aes_block_packer.sv
// aes_block_packer: packs a byte stream into 128-bit plaintext blocks tagged with the key.
//   clk, rst_n (sync, active-low)
//   key_load/key_data : load the 128-bit key register
//   bus (slave)       : byte stream in, block stream out (see aes_block_packer_if)
//   FIFO_DEPTH        : completed blocks buffered toward the core (1 or 2)
//   AES_PAD_PKCS7_EN  : when defined, PKCS#7 padding with an extra pad block after a
//                       message that ends on a block boundary; otherwise zero padding
module aes_block_packer #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_load,
    input  logic [127:0]      key_data,
    aes_block_packer_if.slave bus
);
    typedef enum logic {FILL, PAD} state_t;
    state_t       state, state_nx;
    logic [3:0]   cnt;
    logic [127:0] acc, key_q, blk;
    logic [256:0] mem [2];
    logic [256:0] push_word;
    logic         wr_ptr, rd_ptr;
    logic [1:0]   count;
    logic         full, fills_block, s_fire, complete, pad_push, push, pop, last_bit;
    logic [7:0]   pad_byte;

    // Fullness is taken before any pop on the same edge, so there is no bypass.
    assign full        = count == 2'(FIFO_DEPTH);
    assign fills_block = cnt == 4'd15;
    assign bus.s_ready = state == FILL && !(full && (fills_block || bus.s_last));
    assign s_fire      = bus.s_valid && bus.s_ready;
    assign complete    = s_fire && (fills_block || bus.s_last);
    assign pad_push    = state == PAD && !full;
    assign push        = complete || pad_push;
    assign pop         = bus.m_valid && bus.m_ready;
    assign bus.m_valid = count != 2'd0;
    assign {bus.m_last, bus.m_key, bus.m_plaintext} = mem[rd_ptr];

`ifdef AES_PAD_PKCS7_EN
    assign pad_byte = {4'h0, 4'd15 - cnt};
    // A message ending exactly on byte 15 is closed by the separate pad block.
    assign last_bit = bus.s_last && !fills_block;
`else
    assign pad_byte = 8'h00;
    assign last_bit = bus.s_last;
`endif

    // Insert the current byte; positions after it get the pad value, which later
    // bytes of a non-final block simply overwrite.
    always_comb begin
        blk = acc;
        for (int i = 0; i < 16; i++)
            if (4'(i) == cnt) blk[8*(15-i) +: 8] = bus.s_data;
            else if (4'(i) > cnt) blk[8*(15-i) +: 8] = pad_byte;
    end

    assign push_word = pad_push ? {1'b1, key_q, {16{8'h10}}} : {last_bit, key_q, blk};

    always_comb begin
        state_nx = state;
`ifdef AES_PAD_PKCS7_EN
        if (state == FILL && complete && bus.s_last && fills_block) state_nx = PAD;
        else if (pad_push) state_nx = FILL;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= FILL;
        else state <= state_nx;
    end

    // The key register updates on the same edge a block is pushed, so that block
    // carries the old key.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= 4'd0;
            acc    <= '0;
            key_q  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) mem[i] <= '0;
        end else begin
            if (key_load) key_q <= key_data;
            if (s_fire) begin
                cnt <= complete ? 4'd0 : cnt + 4'd1;
                acc <= complete ? '0 : blk;
            end
            if (push) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= !wr_ptr;
            end
            if (pop) rd_ptr <= !rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule
